add_sequencer: RTL and testbench
================================

ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 The module SHALL have the parameter N, default 4, giving the width of the shared ripple-adder slice in bits.
REQ-002 The module SHALL have the parameter WORDS, default 4, giving the number of slices per operand; operand width W = N*WORDS.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset; it SHALL be sampled only on the rising clk edge.
REQ-005 start  input  1  request to begin an addition; sampled only when the sequencer can accept (REQ-011).
REQ-006 a  input  W  first operand; sampled on the accepted start.
REQ-007 b  input  W  second operand; sampled on the accepted start.
REQ-008 ci  input  1  carry-in into slice 0; sampled on the accepted start.
REQ-009 busy  output  1  high while a computation is in progress (state RUN).
REQ-010 done  output  1  one-cycle pulse marking that sum/co are valid.
REQ-011 ready  output  1  high in IDLE and DONE; start is accepted only when ready=1.
REQ-012 sum  output  W  registered result.
REQ-013 co  output  1  registered carry-out of the most significant slice.

Function
REQ-014 The block SHALL contain exactly one N-bit ripple-carry adder slice (a, b, carry-in -> N-bit sum, carry-out), time-shared across all WORDS slices.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 Transitions SHALL be: IDLE->RUN on start; RUN->RUN while idx<WORDS-1; RUN->DONE when idx=WORDS-1; DONE->RUN on start; DONE->IDLE otherwise.
REQ-017 On an accepted start, the block SHALL latch a, b and ci into internal registers, clear idx to 0, and load the carry register with ci.
REQ-018 Each RUN cycle SHALL feed slice idx of the latched a and b, together with the carry register, into the adder slice.
REQ-019 Each RUN cycle SHALL write the N-bit adder result into bits [idx*N+N-1 : idx*N] of an internal partial-sum register, load the carry register with the slice carry-out, and increment idx.
REQ-020 On the RUN->DONE edge, sum SHALL be loaded with the complete partial sum, co with the final slice carry-out, and done SHALL be asserted.
REQ-021 sum and co SHALL change only on the RUN->DONE edge and SHALL hold their values through IDLE and any subsequent RUN until the next completion.
REQ-022 Latency SHALL be fixed: a start accepted at edge t yields done=1 in the cycle following edge t+WORDS; throughput is one result per WORDS+1 cycles with back-to-back starts.
REQ-023 Arithmetic SHALL be unsigned modulo 2^W, with {co,sum} = a+b+ci exactly.
REQ-024 A start asserted while busy=1 SHALL be ignored, with no effect on the operands, idx or outputs, and SHALL NOT be queued.
REQ-025 A start in DONE SHALL be accepted in the same cycle that done=1 is visible; the pulse still lasts exactly one cycle.
REQ-026 Changes on a, b or ci after acceptance SHALL NOT affect the result in progress.
REQ-027 idx SHALL be ceil(log2(WORDS)) bits wide (minimum 1 bit); the WORDS=1 case SHALL complete in one RUN cycle.

Reset
REQ-028 When rst=1 on an edge, the FSM SHALL go to IDLE and idx, the carry register, the partial-sum register, sum, co, busy and done SHALL all go to 0.
REQ-029 After rst, ready SHALL be 1.
REQ-030 rst SHALL take priority over start.
REQ-031 rst asserted mid-RUN SHALL abandon the computation with no done pulse, and the previous sum SHALL be lost (cleared to 0).

Verification (N=4, WORDS=4)
REQ-032 Reset check: rst held for 2 cycles, then released -> sum=0, co=0, busy=0, done=0, ready=1.
REQ-033 Full carry ripple: a=16'hFFFF, b=16'h0001, ci=0, start pulse -> busy for 4 cycles, then done pulse with sum=16'h0000, co=1.
REQ-034 Carry-in only: a=16'h1234, b=16'h4321, ci=1 -> sum=16'h5556, co=0; cross-slice carry case a=16'h00FF, b=16'h0001, ci=0 -> sum=16'h0100, co=0.
REQ-035 Back-to-back and ignored start: start held high continuously with operands changing every cycle -> only the operands present at each acceptance are used, done every 5 cycles, and mid-RUN operand changes have no effect.
REQ-036 Reset mid-operation: rst asserted in the 3rd RUN cycle -> no done pulse, sum=0, ready=1 next cycle; a new start then completes normally.
REQ-037 Randomized: at least 1000 random (a, b, ci) triples with random start gaps -> {co,sum} always equals a+b+ci, and done is always exactly one cycle wide.

Source files
------------

// File: rtl/add_sequencer.sv
// Multi-cycle adder: one N-bit ripple slice reused WORDS times
// to add two N*WORDS-bit operands, with start/ready/done handshake.
module add_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 ci,
  output logic                 busy,
  output logic                 done,
  output logic                 ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 co
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   ra;
  logic [W-1:0]   rb;
  logic [W-1:0]   psum;
  logic [W-1:0]   psum_nxt;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   ss;
  logic           sc;
  logic           rc;
  logic           last;

  // operand slice selected by idx
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) begin
        sa = ra[i*N +: N];
        sb = rb[i*N +: N];
      end
    end
  end

  // the single shared ripple-carry slice
  always_comb begin
    rc = carry;
    ss = '0;
    for (int k = 0; k < N; k++) begin
      ss[k] = sa[k] ^ sb[k] ^ rc;
      rc    = (sa[k] & sb[k]) | (rc & (sa[k] ^ sb[k]));
    end
    sc = rc;
  end

  always_comb begin
    psum_nxt = psum;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) begin
        psum_nxt[i*N +: N] = ss;
      end
    end
  end

  assign last = (idx == IW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      idx   <= '0;
      carry <= 1'b0;
      psum  <= '0;
      sum   <= '0;
      co    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            carry <= ci;
            idx   <= '0;
            state <= RUN;
            busy  <= 1'b1;
            ready <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        RUN: begin
          psum  <= psum_nxt;
          carry <= sc;
          idx   <= idx + IW'(1);
          if (last) begin
            sum   <= psum_nxt;
            co    <= sc;
            done  <= 1'b1;
            state <= DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sequencer.sv
// Bench for add_sequencer (N=4, WORDS=4): directed table,
// back-to-back, mid-run reset and random ops vs a+b+ci model.
module tb_add_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        busy;
  logic        done;
  logic        ready;
  logic [15:0] sum;
  logic        co;

  int pass_cnt = 0;
  int total = 0;

  add_sequencer #(.N(4), .WORDS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .ready (ready),
    .sum   (sum),
    .co    (co)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vci;
    logic [15:0] esum;
    logic        eco;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                       input logic c, output logic [16:0] r,
                       output int lat, output int bz);
    a = x;
    b = y;
    ci = c;
    start = 1'b1;
    step();
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    ci = 1'($urandom);
    lat = 1;
    bz = 0;
    while (!done && lat < 20) begin
      bz += int'(busy);
      step();
      lat++;
    end
    r = {co, sum};
  endtask

  vec_t vt[7];
  logic [16:0] r;
  logic [16:0] exp17;
  int lat;
  int bz;
  logic [15:0] qa[25];
  logic [15:0] qb[25];
  logic        qc[25];
  logic [16:0] last_res;

  initial begin
    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vt[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vt[2] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vt[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vt[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vt[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    ci = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_sum", 32'(sum), 32'h0);
    chk("reset_co", 32'(co), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_ready", 32'(ready), 32'h1);

    for (int i = 0; i < 7; i++) begin
      do_op(vt[i].va, vt[i].vb, vt[i].vci, r, lat, bz);
      chk($sformatf("vec%0d_sum", i), 32'(r[15:0]), 32'(vt[i].esum));
      chk($sformatf("vec%0d_co", i), 32'(r[16]), 32'(vt[i].eco));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd5);
      chk($sformatf("vec%0d_busy", i), 32'(bz), 32'd4);
      step();
      chk($sformatf("vec%0d_pulse", i), 32'(done), 32'h0);
      chk($sformatf("vec%0d_hold", i), 32'(sum), 32'(vt[i].esum));
    end

    // start held high, operands change every cycle
    last_res = {co, sum};
    start = 1'b1;
    for (int s = 0; s < 21; s++) begin
      if (s > 0) begin
        chk($sformatf("b2b_done%0d", s), 32'(done),
            32'((s % 5) == 0));
        if ((s % 5) == 0) begin
          last_res = 17'(qa[s-5]) + 17'(qb[s-5]) + 17'(qc[s-5]);
        end
        chk($sformatf("b2b_res%0d", s), 32'({co, sum}), 32'(last_res));
      end
      qa[s] = 16'($urandom);
      qb[s] = 16'($urandom);
      qc[s] = 1'($urandom);
      a = qa[s];
      b = qb[s];
      ci = qc[s];
      if (s < 20) step();
    end
    start = 1'b0;
    step();
    step();
    step();

    // reset in third RUN cycle
    do_op(16'h1111, 16'h2222, 1'b0, r, lat, bz);
    chk("pre_rst_sum", 32'(r), 32'h3333);
    step();
    a = 16'h0101;
    b = 16'h0202;
    ci = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("midrun_hold", 32'(sum), 32'h3333);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_sum", 32'({co, sum}), 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    step();
    step();
    step();
    chk("rst_nodone", 32'(done), 32'h0);
    do_op(16'hABCD, 16'h5433, 1'b1, r, lat, bz);
    chk("post_rst_res", 32'(r), 32'h10001);
    chk("post_rst_lat", 32'(lat), 32'd5);

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] x;
      logic [15:0] y;
      logic        c;
      x = 16'($urandom);
      y = 16'($urandom);
      c = 1'($urandom);
      exp17 = 17'(x) + 17'(y) + 17'(c);
      do_op(x, y, c, r, lat, bz);
      chk($sformatf("rnd%0d_res", i), 32'(r), 32'(exp17));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd5);
      step();
      chk($sformatf("rnd%0d_pulse", i), 32'(done), 32'h0);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
